nios2_debug_cmd_queue: RTL and testbench
========================================

Name: nios2_debug_cmd_queue

Overview:
Sysclk-side command receiver for the Nios II JTAG debug path; successor to the fixed 38-bit, 2-bit-IR sysclk capture logic.
- Synchronises the asynchronous update strobes from the virtual-JTAG (tck) domain and edge-detects them.
- Captures the scanned shift register plus IR into a parametrised FIFO, handing commands to the OCI/break/trace logic over a valid/ready handshake.
- Generates per-IR-channel take_action / take_no_action pulses, so back-to-back scans are no longer lost while the core is busy.

Parameters:
SR_W, 38, shift-register / jdo width; bit SR_W-1 is the action flag.
IR_W, 2, IR width; NCH = 2**IR_W decode channels.
DEPTH, 4, FIFO entries; power of two, >= 2.
SYNC_STAGES, 2, synchroniser flops per async strobe; >= 2.

Ports:
clk  in  1  system clock; the only clock.
reset_n  in  1  synchronous, active-low reset.
vs_udr  in  1  async level from tck domain; rising edge = data register updated.
vs_uir  in  1  async level from tck domain; rising edge = IR updated.
ir_in  in  IR_W  IR value; quasi-static, stable whenever a udr edge is detected.
sr  in  SR_W  scanned data; quasi-static, stable whenever a udr edge is detected.
cmd_ready  in  1  consumer accepts the head command.
clr_overflow  in  1  clears the sticky overflow flag.
cmd_valid  out  1  FIFO non-empty.
cmd_ir  out  IR_W  IR of head command.
cmd_jdo  out  SR_W  data of head command.
take_action  out  NCH  one-hot pulse: popped command has jdo[SR_W-1]=1; bit index = its IR.
take_no_action  out  NCH  one-hot pulse: popped command has jdo[SR_W-1]=0.
ir_update  out  1  one-cycle pulse per detected vs_uir rising edge.
fifo_level  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky: a capture was dropped because the FIFO was full.

Behaviour:
Reset (reset_n=0 at a clk edge):
- All synchroniser flops, edge-detect history, FIFO pointers and all outputs go to 0; FIFO contents are don't-care.
- A mid-operation reset discards all queued commands.

Arming after reset:
- A counter masks edge detection for SYNC_STAGES+1 cycles after reset_n rises.
- A strobe already high at release therefore produces no capture or pulse.
- Detection is active from cycle SYNC_STAGES+2 onward.

Edge detect:
- edge = sync_out & ~prev, with prev registered each cycle.
- A vs_udr rising edge at the pin produces a write on the (SYNC_STAGES+1)th clk edge.
- cmd_valid rises on the following cycle, for a total latency of SYNC_STAGES+2 cycles.

Capture:
- On a udr edge, {ir_in, sr} are written to the tail.

FIFO:
- Pop happens when cmd_valid & cmd_ready.
- cmd_ir and cmd_jdo always present the head entry; they are don't-care while cmd_valid=0.
- cmd_ready while empty is ignored.

Full:
- Push without a simultaneous pop drops the new command, leaves contents unchanged and sets overflow.
- Push and pop in the same cycle when full: both proceed, level stays DEPTH, no overflow.
- Push and pop in the same cycle when empty: only the push proceeds; the pop is ignored because cmd_valid=0.

Overflow flag:
- Cleared by clr_overflow.
- If a set and a clear coincide, the set wins.

Action pulses:
- Registered; asserted for exactly one cycle, the cycle after the pop.
- Exactly one bit among take_action | take_no_action is set per pop; all zero otherwise.

ir_update:
- One-cycle registered pulse, same latency as udr capture.
- Fully independent of udr; simultaneous udr and uir edges are both honoured.

Pointers:
- log2(DEPTH)-bit wrap-around read/write pointers plus a separate level counter.
- Level saturates logically at DEPTH by the full rule above, never arithmetically.

Optional Feature:
Macro DBG_CMD_PARITY_EN.
- Defined:
  - Even parity is checked over sr at capture; sr[SR_W-2] is the parity bit.
  - A failing command is not written.
  - A sticky output parity_err (1 bit, reset 0) is set and is cleared by clr_overflow.
  - The parity check takes precedence over overflow: a bad command arriving while full sets only parity_err.
- Undefined: no check, every captured command is written, and no parity_err port exists.

Test Plan:
- Reset hold with vs_udr=1, then release -> no cmd_valid, no pulses for 20 cycles; fifo_level=0.
- Single capture:
  - Stimulus: ir_in=2'b01, sr=38'h20_0000_1234 (bit37=1), vs_udr 0->1; cmd_ready=1 from when cmd_valid rises.
  - Response: cmd_valid rises exactly 4 cycles after the edge; take_action=4'b0010 for 1 cycle after the pop; take_no_action=0.
- Fill and overflow:
  - Stimulus: cmd_ready=0; 5 udr edges with sr=1..5 (bit37=0), ir_in=2'b11.
  - Response: fifo_level=4, overflow=1; draining yields jdo 1,2,3,4 in order; take_no_action=4'b1000 per pop.
- Simultaneous push and pop while full, DEPTH=4 -> level stays 4, overflow stays 0, popped order preserved.
- ir_update and udr edges in the same cycle -> ir_update pulse and FIFO write occur in the same cycle.
- Reset asserted with level=3 -> next cycle cmd_valid=0, fifo_level=0; with DBG_CMD_PARITY_EN, sr with odd parity -> not queued, parity_err=1.

Source files
------------

// File: rtl/nios2_debug_cmd_queue_if.sv
// nios2_debug_cmd_queue_if: valid/ready command handshake between the debug queue and its consumer.
interface nios2_debug_cmd_queue_if #(
    parameter int SR_W = 38,
    parameter int IR_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [SR_W-1:0] cmd_jdo;

    modport master (output cmd_valid, output cmd_ir, output cmd_jdo, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_ir, input cmd_jdo, output cmd_ready);
endinterface

// File: rtl/nios2_debug_cmd_queue.sv
// nios2_debug_cmd_queue: syncs tck-domain update strobes, queues {ir, sr} captures, pulses per-IR actions on pop.
// Optional DBG_CMD_PARITY_EN: even-parity check on sr at capture plus sticky parity_err output.
module nios2_debug_cmd_queue #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int NCH   = 2**IR_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1,
    localparam int ARM_W = $clog2(SYNC_STAGES + 2)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [SR_W-1:0]               sr,
    input  logic                          clr_overflow,
    nios2_debug_cmd_queue_if.master       cmd,
    output logic [NCH-1:0]                take_action,
    output logic [NCH-1:0]                take_no_action,
    output logic                          ir_update,
    output logic [LW-1:0]                 fifo_level,
`ifdef DBG_CMD_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          overflow
);
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
    logic                   udr_prev_q, udr_prev_d, uir_prev_q, uir_prev_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   ovf_q, ovf_d, iru_q, iru_d;
    logic [NCH-1:0]         ta_q, ta_d, tna_q, tna_d;
    logic [IR_W+SR_W-1:0]   mem_q [DEPTH];
    logic [IR_W+SR_W-1:0]   head;
    logic [IR_W-1:0]        head_ir;
    logic                   armed, udr_edge, uir_edge, par_bad, push, pop, full, wr_en, ovf_set;

    always_comb begin
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_prev_d = udr_sync_q[SYNC_STAGES-1];
        uir_prev_d = uir_sync_q[SYNC_STAGES-1];
        // history keeps tracking while disarmed so a strobe held through release never looks like an edge
        armed      = arm_cnt_q == ARM_W'(SYNC_STAGES + 1);
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        udr_edge   = armed & udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
        uir_edge   = armed & uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
`ifdef DBG_CMD_PARITY_EN
        par_bad    = ^sr;
`else
        par_bad    = 1'b0;
`endif
        push       = udr_edge & ~par_bad;
        full       = level_q == LW'(DEPTH);
        pop        = cmd.cmd_valid & cmd.cmd_ready;
        // when full, the slot being written is the head being popped this cycle
        wr_en      = push & (~full | pop);
        ovf_set    = push & full & ~pop;
        wr_ptr_d   = wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + LW'(wr_en) - LW'(pop);
        ovf_d      = ovf_set | (ovf_q & ~clr_overflow);
        head       = mem_q[rd_ptr_q];
        head_ir    = head[IR_W+SR_W-1:SR_W];
        ta_d       = (pop &  head[SR_W-1]) ? NCH'(1) << head_ir : '0;
        tna_d      = (pop & ~head[SR_W-1]) ? NCH'(1) << head_ir : '0;
        iru_d      = uir_edge;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            udr_sync_q <= '0;
            uir_sync_q <= '0;
            udr_prev_q <= 1'b0;
            uir_prev_q <= 1'b0;
            arm_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            ta_q       <= '0;
            tna_q      <= '0;
            iru_q      <= 1'b0;
        end else begin
            udr_sync_q <= udr_sync_d;
            uir_sync_q <= uir_sync_d;
            udr_prev_q <= udr_prev_d;
            uir_prev_q <= uir_prev_d;
            arm_cnt_q  <= arm_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            ta_q       <= ta_d;
            tna_q      <= tna_d;
            iru_q      <= iru_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {ir_in, sr};
    end

`ifdef DBG_CMD_PARITY_EN
    logic perr_q, perr_d;

    always_comb perr_d = (udr_edge & par_bad) | (perr_q & ~clr_overflow);

    always_ff @(posedge clk) begin
        if (!reset_n) perr_q <= 1'b0;
        else          perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`endif

    assign cmd.cmd_valid  = level_q != '0;
    assign cmd.cmd_ir     = head_ir;
    assign cmd.cmd_jdo    = head[SR_W-1:0];
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign ir_update      = iru_q;
    assign fifo_level     = level_q;
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_nios2_debug_cmd_queue.sv
// tb_nios2_debug_cmd_queue: directed and random stimulus against a queue-based reference with a per-cycle monitor.
module tb_nios2_debug_cmd_queue;
    localparam int SR_W = 38, IR_W = 2, DEPTH = 4, S = 2, NCH = 4, LW = 3;
`ifdef DBG_CMD_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    typedef logic [IR_W+SR_W-1:0] ent_t;

    logic clk = 0, reset_n = 0, vs_udr = 0, vs_uir = 0, clr_overflow = 0;
    logic [IR_W-1:0] ir_in = '0;
    logic [SR_W-1:0] sr_i = '0;
    logic [NCH-1:0] take_action, take_no_action;
    logic ir_update, overflow;
    logic [LW-1:0] fifo_level;
`ifdef DBG_CMD_PARITY_EN
    logic parity_err;
`endif

    int vectors = 0, miscompares = 0;

    nios2_debug_cmd_queue_if #(.SR_W(SR_W), .IR_W(IR_W)) cif ();

    nios2_debug_cmd_queue #(.SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr_i),
        .clr_overflow(clr_overflow), .cmd(cif), .take_action(take_action), .take_no_action(take_no_action),
        .ir_update(ir_update), .fifo_level(fifo_level),
`ifdef DBG_CMD_PARITY_EN
        .parity_err(parity_err),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // reference state: expected queue contents and flags
    ent_t mdl_q[$];
    bit mdl_ovf, mdl_perr, exp_iru;
    logic [NCH-1:0] exp_ta, exp_tna;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [SR_W-1:0] fix(input logic [SR_W-1:0] v);
        if (PAR) v[SR_W-2] = v[SR_W-2] ^ (^v);
        return v;
    endfunction

    // reference model: a pin rising edge becomes a capture S+1 clock edges later, once armed
    initial begin
        logic [S+1:0] hu, hi;
        int armcnt;
        bit ue, ie, pop, set, pset;
        ent_t h;
        hu = '0; hi = '0; armcnt = 0;
        mdl_ovf = 0; mdl_perr = 0; exp_iru = 0; exp_ta = '0; exp_tna = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                mdl_q.delete();
                mdl_ovf = 0; mdl_perr = 0; exp_iru = 0; exp_ta = '0; exp_tna = '0;
                hu = '0; hi = '0; armcnt = 0;
            end else begin
                ue = armcnt >= S + 1 && hu[S-1] && !hu[S];
                ie = armcnt >= S + 1 && hi[S-1] && !hi[S];
                if (armcnt < S + 1) armcnt++;
                hu = {hu[S:0], vs_udr};
                hi = {hi[S:0], vs_uir};
                pop = mdl_q.size() != 0 && cif.cmd_ready;
                exp_ta = '0; exp_tna = '0;
                if (pop) begin
                    h = mdl_q.pop_front();
                    if (h[SR_W-1]) exp_ta[h[IR_W+SR_W-1:SR_W]] = 1'b1;
                    else exp_tna[h[IR_W+SR_W-1:SR_W]] = 1'b1;
                end
                set = 0; pset = 0;
                if (ue) begin
                    if (PAR && (^sr_i)) pset = 1;
                    else if (mdl_q.size() == DEPTH) set = 1;
                    else mdl_q.push_back({ir_in, sr_i});
                end
                mdl_ovf = set || (mdl_ovf && !clr_overflow);
                mdl_perr = pset || (mdl_perr && !clr_overflow);
                exp_iru = ie;
            end
        end
    end

    // monitor: compare every output against the reference each cycle
    initial begin
        forever begin
            @(negedge clk);
            chk("cmd_valid", 64'(cif.cmd_valid), 64'(mdl_q.size() != 0));
            chk("fifo_level", 64'(fifo_level), 64'(mdl_q.size()));
            chk("overflow", 64'(overflow), 64'(mdl_ovf));
            chk("take_action", 64'(take_action), 64'(exp_ta));
            chk("take_no_action", 64'(take_no_action), 64'(exp_tna));
            chk("ir_update", 64'(ir_update), 64'(exp_iru));
`ifdef DBG_CMD_PARITY_EN
            chk("parity_err", 64'(parity_err), 64'(mdl_perr));
`endif
            if (cif.cmd_valid && cif.cmd_ready) begin
                if (mdl_q.size() == 0) chk("head_unexpected", 64'(1), 64'(0));
                else chk("head", 64'({cif.cmd_ir, cif.cmd_jdo}), 64'(mdl_q[0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] v);
        ir_in = ir; sr_i = v; vs_udr = 1;
        tick(S + 2);
        vs_udr = 0;
        tick(S + 2);
    endtask

    initial begin
        int cyc;
        cif.cmd_ready = 0;
        // reset held with strobe high, then released: nothing may be captured
        vs_udr = 1; vs_uir = 1;
        tick(5);
        reset_n = 1;
        tick(20);
        @(negedge clk);
        chk("no_capture_after_release", 64'(fifo_level), 64'(0));
        chk("no_irupd_after_release", 64'(ir_update), 64'(0));
        tick(1);
        vs_udr = 0; vs_uir = 0;
        tick(S + 2);

        // single capture and latency
        cif.cmd_ready = 1; ir_in = 2'b01; sr_i = fix(38'h20_0000_1234); vs_udr = 1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cif.cmd_valid) begin cyc = i; break; end
        end
        chk("latency_cycles", 64'(cyc), 64'(S + 2));
        @(negedge clk);
        chk("take_action_single", 64'(take_action), 64'(4'b0010));
        tick(1);
        vs_udr = 0;
        tick(S + 2);

        // fill and overflow
        cif.cmd_ready = 0;
        for (int k = 1; k <= 5; k++) pulse(2'b11, fix(SR_W'(k)));
        @(negedge clk);
        chk("fill_level", 64'(fifo_level), 64'(4));
        chk("fill_overflow", 64'(overflow), 64'(1));
        tick(1);
        cif.cmd_ready = 1;
        tick(6);
        cif.cmd_ready = 0;
        clr_overflow = 1;
        tick(1);
        clr_overflow = 0;
        @(negedge clk);
        chk("overflow_cleared", 64'(overflow), 64'(0));
        tick(1);

        // push and pop together while full
        for (int k = 0; k < 4; k++) pulse(2'(k), fix({$urandom(), $urandom()}));
        ir_in = 2'b10; sr_i = fix({$urandom(), $urandom()}); vs_udr = 1;
        tick(S);
        cif.cmd_ready = 1;
        tick(1);
        cif.cmd_ready = 0;
        @(negedge clk);
        chk("full_pushpop_level", 64'(fifo_level), 64'(4));
        chk("full_pushpop_ovf", 64'(overflow), 64'(0));
        tick(1);
        vs_udr = 0;
        cif.cmd_ready = 1;
        tick(8);
        cif.cmd_ready = 0;

        // simultaneous udr and uir edges
        ir_in = 2'b00; sr_i = fix(38'h1_5555); vs_udr = 1; vs_uir = 1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ir_update) begin cyc = i; break; end
        end
        chk("irupd_seen", 64'(cyc != 0), 64'(1));
        chk("irupd_with_write", 64'(cif.cmd_valid), 64'(1));
        tick(1);
        vs_udr = 0; vs_uir = 0;
        tick(S + 2);

        // mid-operation reset with level 3
        for (int k = 0; k < 2; k++) pulse(2'(k), fix({$urandom(), $urandom()}));
        @(negedge clk);
        chk("pre_reset_level", 64'(fifo_level), 64'(3));
        tick(1);
        reset_n = 0;
        tick(1);
        reset_n = 1;
        @(negedge clk);
        chk("reset_valid", 64'(cif.cmd_valid), 64'(0));
        chk("reset_level", 64'(fifo_level), 64'(0));
        tick(S + 3);

`ifdef DBG_CMD_PARITY_EN
        pulse(2'b01, fix(38'h0_0000_0777) ^ 38'h1);
        @(negedge clk);
        chk("parity_err_set", 64'(parity_err), 64'(1));
        chk("parity_not_queued", 64'(fifo_level), 64'(0));
        tick(1);
        clr_overflow = 1;
        tick(1);
        clr_overflow = 0;
`endif

        // randomized traffic, including occasional bad parity and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 5) == 0) vs_uir = ~vs_uir;
            if ($urandom_range(0, 3) == 0) begin
                ir_in = 2'($urandom());
                sr_i = SR_W'({$urandom(), $urandom()});
                if ($urandom_range(0, 7) != 0) sr_i = fix(sr_i);
            end
            cif.cmd_ready = $urandom_range(0, 2) == 0;
            clr_overflow = $urandom_range(0, 15) == 0;
            reset_n = $urandom_range(0, 799) != 0;
            tick(1);
        end
        reset_n = 1; clr_overflow = 0; vs_udr = 0; vs_uir = 0; cif.cmd_ready = 1;
        tick(10);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
